// File: rtl/routelogic_center_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | routelogic_center_arb                                                    |
// | Star-hub crossbar: per-output round-robin arbitration into one-entry     |
// | holding registers; flits addressed past the last arm are dropped.        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module routelogic_center_arb #(
   parameter int N_PORTS = 4,
   parameter int ADDR_W  = 4,
   parameter int DATA_W  = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [N_PORTS-1:0]        in_valid,
   input  logic [N_PORTS*ADDR_W-1:0] in_src,
   input  logic [N_PORTS*ADDR_W-1:0] in_dest,
   input  logic [N_PORTS*DATA_W-1:0] in_data,
   output logic [N_PORTS-1:0]        in_ready,
   output logic [N_PORTS-1:0]        out_valid,
   output logic [N_PORTS*ADDR_W-1:0] out_src,
   output logic [N_PORTS*DATA_W-1:0] out_data,
   input  logic [N_PORTS-1:0]        out_ready,
   output logic [7:0]                drop_cnt
);
   localparam int PTR_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

   logic [N_PORTS-1:0]                legal;
   logic [N_PORTS-1:0]                drop;
   logic [N_PORTS-1:0][PTR_W-1:0]     target;
   logic [N_PORTS-1:0][N_PORTS-1:0]   gnt_mat;   // [output][input]

   logic [7:0] drop_q, drop_d;
   logic [8:0] drop_sum;

   for (genvar i = 0; i < N_PORTS; i++) begin : g_arm
      logic [ADDR_W-1:0] src;
      logic [ADDR_W-1:0] dest;
      assign src       = in_src[i*ADDR_W +: ADDR_W];
      assign dest      = in_dest[i*ADDR_W +: ADDR_W];
      assign legal[i]  = 32'(dest) < 32'(N_PORTS);
      assign drop[i]   = in_valid[i] & ~legal[i];
      // A flit addressed to its own source is delivered on the local arm 0.
      assign target[i] = (src == dest) ? '0 : dest[PTR_W-1:0];
   end

   for (genvar j = 0; j < N_PORTS; j++) begin : g_out
      logic [N_PORTS-1:0] req;
      logic               found;
      logic               win;
      logic [PTR_W-1:0]   gnt_idx;
      logic [PTR_W-1:0]   idx_w;
      int                 idx;

      logic               valid_q, valid_d;
      logic [ADDR_W-1:0]  src_q, src_d;
      logic [DATA_W-1:0]  data_q, data_d;
      logic [PTR_W-1:0]   rr_q, rr_d;

      always_comb begin
         req = '0;
         for (int i = 0; i < N_PORTS; i++) begin
            req[i] = in_valid[i] & legal[i] & (target[i] == PTR_W'(j));
         end
      end

      always_comb begin
         found   = 1'b0;
         gnt_idx = '0;
         idx     = 0;
         idx_w   = '0;
         for (int k = 0; k < N_PORTS; k++) begin
            idx = int'(rr_q) + k;
            if (idx >= N_PORTS) begin
               idx = idx - N_PORTS;
            end
            idx_w = PTR_W'(idx);
            if (!found && req[idx_w]) begin
               found   = 1'b1;
               gnt_idx = idx_w;
            end
         end
      end

      // A full register frees up in the same cycle it is being consumed.
      assign win        = found & (~valid_q | out_ready[j]);
      assign gnt_mat[j] = win ? (N_PORTS'(1) << gnt_idx) : '0;

      always_comb begin
         valid_d = valid_q & ~out_ready[j];
         src_d   = src_q;
         data_d  = data_q;
         rr_d    = rr_q;
         if (win) begin
            valid_d = 1'b1;
            src_d   = in_src[int'(gnt_idx)*ADDR_W +: ADDR_W];
            data_d  = in_data[int'(gnt_idx)*DATA_W +: DATA_W];
            rr_d    = (int'(gnt_idx) == N_PORTS - 1) ? '0 : gnt_idx + 1'b1;
         end
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            valid_q <= 1'b0;
            src_q   <= '0;
            data_q  <= '0;
            rr_q    <= '0;
         end else begin
            valid_q <= valid_d;
            src_q   <= src_d;
            data_q  <= data_d;
            rr_q    <= rr_d;
         end
      end

      assign out_valid[j]                  = valid_q;
      assign out_src[j*ADDR_W +: ADDR_W]   = src_q;
      assign out_data[j*DATA_W +: DATA_W]  = data_q;
   end

   always_comb begin
      in_ready = '0;
      for (int i = 0; i < N_PORTS; i++) begin
         in_ready[i] = drop[i];
         for (int j = 0; j < N_PORTS; j++) begin
            in_ready[i] = in_ready[i] | gnt_mat[j][i];
         end
      end
      if (rst) begin
         in_ready = '0;
      end
   end

   assign drop_sum = {1'b0, drop_q} + 9'($countones(drop));
   assign drop_d   = drop_sum[8] ? 8'hFF : drop_sum[7:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         drop_q <= '0;
      end else begin
         drop_q <= drop_d;
      end
   end

   assign drop_cnt = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_routelogic_center_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_routelogic_center_arb                                                 |
// | Self-checking bench: vector table, corner sequences, random vs model.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_routelogic_center_arb;
   localparam int N  = 4;
   localparam int AW = 4;
   localparam int DW = 8;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    in_valid, in_ready, out_valid, out_ready;
   logic [N*AW-1:0] in_src, in_dest, out_src;
   logic [N*DW-1:0] in_data, out_data;
   logic [7:0]      drop_cnt;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   routelogic_center_arb #(.N_PORTS(N), .ADDR_W(AW), .DATA_W(DW)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_src    (in_src),
      .in_dest   (in_dest),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_src   (out_src),
      .out_data  (out_data),
      .out_ready (out_ready),
      .drop_cnt  (drop_cnt)
   );

   // Reference model: one holding slot and one pointer per output.
   logic          m_valid [N];
   logic [AW-1:0] m_src   [N];
   logic [DW-1:0] m_data  [N];
   int            m_rr    [N];
   int            m_drop;
   int            g_arm   [N];
   logic [N-1:0]  exp_rdy;
   int            n_drop;

   typedef struct {
      logic [3:0]  valid;
      logic [15:0] src;
      logic [15:0] dest;
      logic [31:0] data;
      logic [3:0]  exp_rdy;
      logic [3:0]  exp_ov;
      int          chk_port;
      logic [3:0]  exp_src;
      logic [7:0]  exp_data;
      logic [7:0]  exp_drop;
   } vec_t;

   vec_t tbl [8];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic int arm_target(input int i);
      int s, d;
      s = int'(in_src[i*AW +: AW]);
      d = int'(in_dest[i*AW +: AW]);
      if (d >= N) return -1;
      return (s == d) ? 0 : d;
   endfunction

   task automatic model_reset();
      for (int j = 0; j < N; j++) begin
         m_valid[j] = 1'b0;
         m_src[j]   = '0;
         m_data[j]  = '0;
         m_rr[j]    = 0;
      end
      m_drop = 0;
   endtask

   task automatic model_eval();
      exp_rdy = '0;
      n_drop  = 0;
      for (int j = 0; j < N; j++) begin
         g_arm[j] = -1;
         if (!m_valid[j] || out_ready[j]) begin
            for (int k = 0; k < N; k++) begin
               int i;
               i = (m_rr[j] + k) % N;
               if (g_arm[j] < 0 && in_valid[i] && arm_target(i) == j) g_arm[j] = i;
            end
         end
         if (g_arm[j] >= 0) exp_rdy[g_arm[j]] = 1'b1;
      end
      for (int i = 0; i < N; i++) begin
         if (in_valid[i] && arm_target(i) < 0) begin
            exp_rdy[i] = 1'b1;
            n_drop++;
         end
      end
   endtask

   task automatic model_commit();
      for (int j = 0; j < N; j++) begin
         if (g_arm[j] >= 0) begin
            m_valid[j] = 1'b1;
            m_src[j]   = in_src[g_arm[j]*AW +: AW];
            m_data[j]  = in_data[g_arm[j]*DW +: DW];
            m_rr[j]    = (g_arm[j] + 1) % N;
         end else if (out_ready[j]) begin
            m_valid[j] = 1'b0;
         end
      end
      m_drop = (m_drop + n_drop > 255) ? 255 : m_drop + n_drop;
   endtask

   task automatic check_outputs();
      logic [N-1:0] ov;
      for (int j = 0; j < N; j++) ov[j] = m_valid[j];
      check("out_valid", out_valid, ov);
      for (int j = 0; j < N; j++) begin
         if (m_valid[j]) begin
            check($sformatf("out_src[%0d]", j), out_src[j*AW +: AW], m_src[j]);
            check($sformatf("out_data[%0d]", j), out_data[j*DW +: DW], m_data[j]);
         end
      end
      check("drop_cnt", drop_cnt, m_drop[7:0]);
   endtask

   // Entered and left at posedge+1 with inputs already applied.
   task automatic tick();
      model_eval();
      #3;
      check("in_ready", in_ready, exp_rdy);
      @(posedge clk);
      #1;
      model_commit();
      check_outputs();
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      in_valid  = '0;
      out_ready = '0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
   endtask

   task automatic set_arm(input int i, input logic v, input logic [AW-1:0] s,
                          input logic [AW-1:0] d, input logic [DW-1:0] x);
      in_valid[i]          = v;
      in_src[i*AW +: AW]   = s;
      in_dest[i*AW +: AW]  = d;
      in_data[i*DW +: DW]  = x;
   endtask

   initial begin
      logic [3:0] contention_exp [4];
      rst       = 1'b1;
      in_valid  = '0;
      in_src    = '0;
      in_dest   = '0;
      in_data   = '0;
      out_ready = '0;
      model_reset();

      // Reset state while rst is held.
      #2;
      check("reset out_valid", out_valid, 4'b0000);
      check("reset drop_cnt", drop_cnt, 8'd0);
      check("reset in_ready", in_ready, 4'b0000);
      @(posedge clk);
      #1;

      //        valid    src       dest      data          rdy      ov     port src   data   drop
      tbl[0] = '{4'b0100, 16'h0200, 16'h0200, 32'h00A50000, 4'b0100, 4'b0001, 0, 4'h2, 8'hA5, 8'd0};
      tbl[1] = '{4'b1111, 16'h3210, 16'h0321, 32'h44332211, 4'b1111, 4'b1111, 2, 4'h1, 8'h22, 8'd0};
      tbl[2] = '{4'b1110, 16'h3210, 16'h0000, 32'hCCBBAA00, 4'b0010, 4'b0001, 0, 4'h1, 8'hAA, 8'd0};
      tbl[3] = '{4'b1111, 16'h3210, 16'h3333, 32'h0D0C0B0A, 4'b1001, 4'b1001, 0, 4'h3, 8'h0D, 8'd0};
      tbl[4] = '{4'b0011, 16'h0010, 16'h0072, 32'h0000FF5A, 4'b0011, 4'b0100, 2, 4'h0, 8'h5A, 8'd1};
      tbl[5] = '{4'b0000, 16'h1234, 16'h3217, 32'h12345678, 4'b0000, 4'b0000, -1, 4'h0, 8'h00, 8'd0};
      tbl[6] = '{4'b1001, 16'h1000, 16'h1000, 32'h77000066, 4'b0001, 4'b0001, 0, 4'h0, 8'h66, 8'd0};
      tbl[7] = '{4'b0010, 16'h0030, 16'h0920, 32'h00001100, 4'b0010, 4'b0100, 2, 4'h3, 8'h11, 8'd0};

      for (int t = 0; t < 8; t++) begin
         do_reset();
         in_valid = tbl[t].valid;
         in_src   = tbl[t].src;
         in_dest  = tbl[t].dest;
         in_data  = tbl[t].data;
         #3;
         check($sformatf("tbl%0d in_ready", t), in_ready, tbl[t].exp_rdy);
         @(posedge clk);
         #1;
         check($sformatf("tbl%0d out_valid", t), out_valid, tbl[t].exp_ov);
         check($sformatf("tbl%0d drop_cnt", t), drop_cnt, tbl[t].exp_drop);
         if (tbl[t].chk_port >= 0) begin
            check($sformatf("tbl%0d out_src", t), out_src[tbl[t].chk_port*AW +: AW], tbl[t].exp_src);
            check($sformatf("tbl%0d out_data", t), out_data[tbl[t].chk_port*DW +: DW], tbl[t].exp_data);
         end
      end

      // Three arms contend for output 0 which drains every cycle.
      contention_exp[0] = 4'b0010;
      contention_exp[1] = 4'b0100;
      contention_exp[2] = 4'b1000;
      contention_exp[3] = 4'b0010;
      do_reset();
      for (int i = 1; i < 4; i++) set_arm(i, 1'b1, AW'(i), 4'd0, DW'(8'h10 + i));
      out_ready = 4'b0001;
      for (int c = 0; c < 4; c++) begin
         #3;
         check($sformatf("contention grant %0d", c), in_ready, contention_exp[c]);
         #2;
         @(posedge clk);
         #1;
         check($sformatf("contention src %0d", c), out_src[3:0], 4'(c % 3 + 1));
      end

      // Output 3 stalled with a flit held while arm 0 waits for it.
      do_reset();
      set_arm(1, 1'b1, 4'd1, 4'd3, 8'h3C);
      tick();
      in_valid = '0;
      set_arm(0, 1'b1, 4'd0, 4'd3, 8'h99);
      for (int c = 0; c < 5; c++) begin
         tick();
         check("backpressure hold data", out_data[3*DW +: DW], 8'h3C);
      end
      out_ready = 4'b1000;
      tick();
      check("backpressure new data", out_data[3*DW +: DW], 8'h99);
      check("backpressure valid", out_valid[3], 1'b1);
      in_valid  = '0;
      out_ready = '0;

      // Illegal destination repeated past the counter's saturation point.
      do_reset();
      set_arm(0, 1'b1, 4'd0, 4'd7, 8'hEE);
      for (int c = 1; c <= 300; c++) begin
         tick();
         if (c == 254) check("drop_cnt at 254", drop_cnt, 8'd254);
      end
      check("drop_cnt saturated", drop_cnt, 8'd255);
      check("illegal never forwarded", out_valid, 4'b0000);

      // Asynchronous reset with all outputs full and a nonzero drop count.
      do_reset();
      in_valid = '0;
      set_arm(0, 1'b1, 4'd0, 4'd9, 8'h01);
      tick();
      for (int i = 0; i < 4; i++) set_arm(i, 1'b1, AW'(i), AW'((i + 1) % 4), DW'(8'hC0 + i));
      tick();
      check("pre-reset out_valid", out_valid, 4'b1111);
      #2;
      rst = 1'b1;
      #1;
      check("async reset out_valid", out_valid, 4'b0000);
      check("async reset drop_cnt", drop_cnt, 8'd0);
      check("async reset in_ready", in_ready, 4'b0000);
      check("async reset out_src", out_src, 16'h0000);
      check("async reset out_data", out_data, 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      in_valid = '0;
      set_arm(2, 1'b1, 4'd2, 4'd2, 8'hA5);
      tick();
      check("first edge after reset", out_data[7:0], 8'hA5);

      // Randomised traffic against the model.
      do_reset();
      for (int c = 0; c < 2000; c++) begin
         for (int i = 0; i < N; i++) begin
            logic [AW-1:0] s, d;
            d = AW'($urandom_range(0, 7));
            s = AW'($urandom_range(0, 7));
            if (d >= AW'(N) && s == d) s = s ^ 4'd1;
            set_arm(i, 1'($urandom_range(0, 3) != 0), s, d, DW'($urandom));
         end
         out_ready = N'($urandom);
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire

// File: doc/routelogic_center_arb.md
ROUTELOGIC_CENTER_ARB -- requirements
Module: routelogic_center_arb

Interface
Parameters (name, default, meaning):
REQ-001 SHALL have parameter N_PORTS, default 4, number of star arms; legal range 2..16.
REQ-002 SHALL have parameter ADDR_W, default 4, width of source/destination address; ADDR_W >= clog2(N_PORTS).
REQ-003 SHALL have parameter DATA_W, default 8, flit payload width.

Ports (name, direction, width, meaning):
REQ-004 SHALL have clk, input, 1, single clock; all state updates on its rising edge.
REQ-005 SHALL have rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have in_valid, input, N_PORTS, flit present on input arm i.
REQ-007 SHALL have in_src, input, N_PORTS*ADDR_W, source address of flit on arm i, slice i.
REQ-008 SHALL have in_dest, input, N_PORTS*ADDR_W, destination address of flit on arm i, slice i.
REQ-009 SHALL have in_data, input, N_PORTS*DATA_W, payload on arm i, slice i.
REQ-010 SHALL have in_ready, output, N_PORTS, flit on arm i accepted this cycle.
REQ-011 SHALL have out_valid, output, N_PORTS, flit held for output arm j.
REQ-012 SHALL have out_src, output, N_PORTS*ADDR_W, source address of held flit, slice j.
REQ-013 SHALL have out_data, output, N_PORTS*DATA_W, payload of held flit, slice j.
REQ-014 SHALL have out_ready, input, N_PORTS, downstream arm j consumes the held flit.
REQ-015 SHALL have drop_cnt, output, 8, count of dropped flits.

Function
REQ-016 Routing: target port = 0 (local) when in_src == in_dest; otherwise in_dest; inputs with in_dest >= N_PORTS are illegal.
REQ-017 Illegal flit SHALL be accepted (in_ready=1) in the cycle it is valid, never forwarded, and increment drop_cnt, saturating at 255.
REQ-018 Each output j SHALL have a one-entry holding register (valid, src, data); out_* drive the register directly.
REQ-019 Output j SHALL be free when its register is empty or out_ready[j]=1 in the same cycle.
REQ-020 For each free output j, one requester among valid inputs targeting j SHALL be granted by round-robin starting from rr_ptr[j].
REQ-021 in_ready[i] SHALL be 1 exactly when arm i is granted or dropped; combinational from in_valid, in_src, in_dest, out_ready and state.
REQ-022 On grant, the flit SHALL be written to register j at the next edge; latency input-accept to out_valid = 1 cycle.
REQ-023 On grant to arm i, rr_ptr[j] SHALL become (i+1) mod N_PORTS; with no grant rr_ptr[j] SHALL hold.
REQ-024 Simultaneous consume and grant on output j: register SHALL be overwritten with the new flit, out_valid stays 1, no bubble.
REQ-025 Consume without grant: out_valid[j] SHALL fall to 0 at the next edge.
REQ-026 out_valid[j]=1 with out_ready[j]=0: out_src and out_data SHALL remain stable; all requesters to j see in_ready=0.
REQ-027 Different outputs SHALL arbitrate independently; up to N_PORTS grants per cycle.
REQ-028 No flit SHALL be duplicated or lost except illegal drops under REQ-017.

Reset
REQ-029 While rst=1, asynchronously: out_valid=0, out_src=0, out_data=0, every rr_ptr=0, drop_cnt=0.
REQ-030 Reset mid-operation SHALL discard all held flits; in_ready SHALL be 0 while rst=1.
REQ-031 First edge after rst deasserts SHALL perform normal arbitration.

Verification
REQ-032 Local: arm 2 sends src=2,dest=2,data=0xA5 -> in_ready[2]=1; next cycle out_valid[0]=1, out_src[0]=2, out_data[0]=0xA5.
REQ-033 Contention: arms 1,2,3 hold dest=0 continuously, out_ready[0]=1 -> grants in order 1,2,3,1 on consecutive cycles.
REQ-034 Backpressure: out_valid[3]=1, out_ready[3]=0 for 5 cycles with arm 0 requesting dest=3 -> in_ready[0]=0 and out_data[3] stable all 5 cycles; accept follows the cycle out_ready[3] rises.
REQ-035 Illegal: N_PORTS=4, dest=7 for 300 valid cycles -> no out_valid asserts, drop_cnt reaches 255 and holds.
REQ-036 Parallel: arms 0->1, 1->2, 2->3, 3->0 simultaneously -> all in_ready=1 same cycle, all out_valid=1 next cycle.
REQ-037 Reset: assert rst while out_valid=4'b1111 -> out_valid=0 and drop_cnt=0 immediately, before the next edge.
